retire_trace_buf: RTL and testbench
===================================

# retire_trace_buf

Synthesizable, parametrised retire-trace capture buffer for the superscalar RV32I core. Each cycle it accepts up to LANES retired-instruction records from the memory-stage retire ports, optionally filtering non-writing instructions. It stamps each record with a cycle count and queues it in program order. Records drain one per cycle over a valid/ready port to an on-chip consumer such as the UART trace formatter, replacing simulation-only trace printing.

## Interface
Parameters:
- LANES, 2, retire lanes per cycle (1..4); lane 0 is oldest in program order
- DEPTH, 16, record slots (power of two, ≥ 2·LANES)
- CNT_W, 16, drop-counter width

Ports:
- CLK  in  1  clock; all state on rising edge
- NRST  in  1  reset, asynchronous, active-low
- en  in  1  capture enable; 0 ignores all lanes
- filter_nodest  in  1  1 = discard records of kind NONE
- flush  in  1  synchronous clear of queue contents; counters kept
- ret_valid  in  LANES  per-lane retire valid
- ret_pc  in  LANES×32  byte PC per lane
- ret_inst  in  LANES×32  instruction word
- ret_kind  in  LANES×2  0 NONE, 1 REG, 2 LOAD, 3 STORE
- ret_rd  in  LANES×5  destination register
- ret_data  in  LANES×32  written value (REG/LOAD) or store data
- ret_addr  in  LANES×32  memory address (LOAD/STORE), else don't-care
- out_valid  out  1  head record valid
- out_ready  in  1  consumer accepts head
- out_pc, out_inst, out_data, out_addr, out_stamp  out  32 each  head record fields
- out_kind  out  2; out_rd  out  5
- level  out  $clog2(DEPTH)+1  occupied slots
- overflow  out  1  sticky; set on any dropped group
- drop_cnt  out  CNT_W  dropped records, saturating

## Operation
- Accepted lane: en & ret_valid[i] & !(filter_nodest & ret_kind[i]==NONE). Let n = number of accepted lanes.
- Accepted lanes compact in ascending lane order into consecutive slots at the write pointer. Record = fields + out_stamp = free-running 32-bit cycle counter value of that cycle. The counter wraps and increments every cycle after reset.
- Space check uses level at start of cycle; a same-cycle pop does not credit space. If n > DEPTH − level, the whole group is dropped: nothing written, overflow←1, drop_cnt += n saturating at 2^CNT_W−1. A partial write is never allowed.
- Pop occurs when out_valid & out_ready. Push and pop are allowed in the same cycle; level' = level + n_written − pop.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- flush: level←0, pointers←0, out_valid←0. Overflow, drop_cnt and stamp are not cleared. Flush takes priority over push and pop in the same cycle; that cycle's lanes are discarded and not counted as dropped.
- Reset values: level 0, out_valid 0, all out_* fields 0, overflow 0, drop_cnt 0, stamp 0. Reset mid-drain discards the queue immediately.

## Timing
- Capture-to-output latency 1 cycle: a record written at edge k is visible with out_valid=1 after edge k when the queue was empty.
- Head fields are stable while out_valid & !out_ready. The next record appears in the cycle after a pop.
- Sustained throughput: up to LANES in, 1 out per cycle. Under full-width retirement the buffer fills by design, and software reads overflow.
- No combinational path from ret_* to out_*. out_ready only affects the next state.

## Structure
- Package trace_pkg:
  - kind encodings TK_NONE/TK_REG/TK_LOAD/TK_STORE
  - packed record struct trace_rec_t (167 bits)
  - REC_W constant
- Sub-module trace_mwfifo: a multi-write (LANES), single-read FIFO of trace_rec_t with level output.
- Top level does lane filtering, compaction (prefix-count offsets), the stamp counter, the drop policy and the counters.

## Test plan
- Reset, then lane0 REG pc 0x8000 rd 5 data 0x1234 → after 1 cycle out_valid=1, out_pc 0x8000, out_rd 5, out_stamp = capture cycle, level 1.
- Both lanes valid, lane0 pc 0x8004, lane1 pc 0x8008, out_ready=1 → out_pc 0x8004 then 0x8008 on consecutive cycles.
- filter_nodest=1, lane0 NONE, lane1 STORE addr 0xf95c → only the STORE is queued; level 1; order preserved.
- out_ready=0, two lanes every cycle with DEPTH 16 → after 8 cycles level 16. The 9th group is dropped: overflow=1, drop_cnt=2, level stays 16.
- Full queue with out_ready=1 and 1 lane incoming → dropped (no pop credit), drop_cnt +1, level 15.
- Assert flush with 5 queued and lanes valid → level 0 and out_valid 0 next cycle; drop_cnt unchanged. Assert NRST low mid-drain → all outputs 0 asynchronously.

Source files
------------

// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared types for the retire-trace capture path.
//   trace_kind_e : record kind (NONE / REG / LOAD / STORE)
//   trace_rec_t  : one queued retire record including its cycle stamp (167 bits)
//   REC_W        : width of trace_rec_t in bits
// ---------------------------------------------------------------------------
package trace_pkg;

    typedef enum logic [1:0] {
        TK_NONE  = 2'd0,
        TK_REG   = 2'd1,
        TK_LOAD  = 2'd2,
        TK_STORE = 2'd3
    } trace_kind_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        trace_kind_e kind;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] stamp;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/retire_trace_buf_if.sv
// ---------------------------------------------------------------------------
// retire_trace_buf_if
// Retire-lane inputs and the valid/ready record output of retire_trace_buf.
//   master : retire stage + trace consumer side (drives ret_*, out_ready)
//   slave  : the trace buffer (drives out_valid and the head record fields)
// ---------------------------------------------------------------------------
interface retire_trace_buf_if #(
    parameter int LANES = 2
) ();

    logic [LANES-1:0]        ret_valid;
    logic [LANES-1:0][31:0]  ret_pc;
    logic [LANES-1:0][31:0]  ret_inst;
    logic [LANES-1:0][1:0]   ret_kind;
    logic [LANES-1:0][4:0]   ret_rd;
    logic [LANES-1:0][31:0]  ret_data;
    logic [LANES-1:0][31:0]  ret_addr;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [1:0]  out_kind;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic [31:0] out_stamp;

    modport master (
        output ret_valid, ret_pc, ret_inst, ret_kind, ret_rd, ret_data, ret_addr,
        output out_ready,
        input  out_valid, out_pc, out_inst, out_kind, out_rd, out_data, out_addr, out_stamp
    );

    modport slave (
        input  ret_valid, ret_pc, ret_inst, ret_kind, ret_rd, ret_data, ret_addr,
        input  out_ready,
        output out_valid, out_pc, out_inst, out_kind, out_rd, out_data, out_addr, out_stamp
    );

endinterface

// File: rtl/trace_mwfifo.sv
// ---------------------------------------------------------------------------
// trace_mwfifo
// Multi-write (up to LANES per cycle), single-read FIFO of trace_rec_t.
//   CLK, NRST : clock, async active-low reset
//   flush     : synchronous clear of pointers and level
//   wr_cnt    : number of records to write this cycle (already compacted)
//   wr_rec    : compacted records, slot 0 is written first
//   rd_en     : pop the head (ignored when empty)
//   head      : record at the read pointer (meaningful only when level != 0)
//   level     : occupied slots
// The caller guarantees wr_cnt never exceeds the free space.
// ---------------------------------------------------------------------------
module trace_mwfifo
    import trace_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 16
) (
    input  logic                          CLK,
    input  logic                          NRST,
    input  logic                          flush,
    input  logic [$clog2(DEPTH):0]        wr_cnt,
    input  trace_rec_t [LANES-1:0]        wr_rec,
    input  logic                          rd_en,
    output trace_rec_t                    head,
    output logic [$clog2(DEPTH):0]        level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [REC_W-1:0] mem [DEPTH];
    logic             pop;

    assign pop = rd_en && (level != '0);

    // NOTE: the storage array has no reset; stale slots are never observed
    // because the top gates every head field with out_valid.
    always_ff @(posedge CLK) begin
        for (int j = 0; j < LANES; j++) begin
            if (!flush && (LW'(j) < wr_cnt)) begin
                mem[wr_ptr + PW'(j)] <= wr_rec[j];
            end
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Pointers are PW bits wide, so the additions wrap modulo DEPTH.
            wr_ptr <= wr_ptr + wr_cnt[PW-1:0];
            rd_ptr <= rd_ptr + PW'(pop);
            level  <= level + wr_cnt - LW'(pop);
        end
    end

    assign head = trace_rec_t'(mem[rd_ptr]);

endmodule

// File: rtl/retire_trace_buf.sv
// ---------------------------------------------------------------------------
// retire_trace_buf
// Retire-trace capture buffer: filters and compacts up to LANES retired
// instructions per cycle, stamps them with a free-running cycle counter and
// queues them in program order; records drain one per cycle.
//   CLK, NRST     : clock, async active-low reset
//   en            : capture enable
//   filter_nodest : drop records of kind NONE before queuing
//   flush         : clear queue contents (counters and stamp kept)
//   bus           : retire lanes in, valid/ready record out (slave side)
//   level         : occupied slots
//   overflow      : sticky, set when a whole group was dropped for lack of room
//   drop_cnt      : saturating count of dropped records
// ---------------------------------------------------------------------------
module retire_trace_buf
    import trace_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   NRST,
    input  logic                   en,
    input  logic                   filter_nodest,
    input  logic                   flush,
    retire_trace_buf_if.slave      bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [31:0]               stamp;
    logic [LANES-1:0]          acc;
    logic [LANES-1:0][LW-1:0]  off;
    logic [LW-1:0]             n_acc;
    trace_rec_t [LANES-1:0]    lane_rec;
    trace_rec_t [LANES-1:0]    comp;
    logic [LW-1:0]             space;
    logic                      drop;
    logic [LW-1:0]             wr_cnt;
    logic                      pop;
    trace_rec_t                head;
    logic [CNT_W:0]            drop_sum;

    // Filtering plus prefix-count compaction: off[i] is the number of
    // accepted lanes older than lane i, i.e. its slot within this group.
    // NOTE: n_acc is a running sum inside one combinational pass, so it must
    // use blocking assignments; a non-blocking one would read a stale value.
    always_comb begin
        acc      = '0;
        off      = '0;
        n_acc    = '0;
        lane_rec = '0;
        comp     = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_rec[i] = '{pc:    bus.ret_pc[i],
                            inst:  bus.ret_inst[i],
                            kind:  trace_kind_e'(bus.ret_kind[i]),
                            rd:    bus.ret_rd[i],
                            data:  bus.ret_data[i],
                            addr:  bus.ret_addr[i],
                            stamp: stamp};
            acc[i] = en && bus.ret_valid[i]
                     && !(filter_nodest && (trace_kind_e'(bus.ret_kind[i]) == TK_NONE));
            off[i] = n_acc;
            n_acc  = n_acc + LW'(acc[i]);
        end
        for (int j = 0; j < LANES; j++) begin
            for (int i = 0; i < LANES; i++) begin
                if (acc[i] && (off[i] == LW'(j))) begin
                    comp[j] = lane_rec[i];
                end
            end
        end
    end

    // Space is judged on the level at the start of the cycle; a pop in the
    // same cycle does not make room, and a group is written whole or not at all.
    assign space  = LW'(DEPTH) - level;
    assign drop   = n_acc > space;
    assign wr_cnt = (flush || drop) ? '0 : n_acc;
    assign pop    = bus.out_valid && bus.out_ready;

    trace_mwfifo #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .NRST   (NRST),
        .flush  (flush),
        .wr_cnt (wr_cnt),
        .wr_rec (comp),
        .rd_en  (pop),
        .head   (head),
        .level  (level)
    );

    assign drop_sum = {1'b0, drop_cnt} + (CNT_W + 1)'(n_acc);

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            stamp    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            stamp <= stamp + 32'd1;
            // A flushed cycle discards its lanes without counting them.
            if (!flush && drop) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
        end
    end

    assign bus.out_valid = (level != '0);
    assign bus.out_pc    = bus.out_valid ? head.pc    : '0;
    assign bus.out_inst  = bus.out_valid ? head.inst  : '0;
    assign bus.out_kind  = bus.out_valid ? head.kind  : '0;
    assign bus.out_rd    = bus.out_valid ? head.rd    : '0;
    assign bus.out_data  = bus.out_valid ? head.data  : '0;
    assign bus.out_addr  = bus.out_valid ? head.addr  : '0;
    assign bus.out_stamp = bus.out_valid ? head.stamp : '0;

endmodule

// File: tb/tb_retire_trace_buf.sv
// ---------------------------------------------------------------------------
// tb_retire_trace_buf
// Directed scenarios followed by a randomized run checked against a
// queue-based reference model of the trace buffer.
// ---------------------------------------------------------------------------
module tb_retire_trace_buf;
    import trace_pkg::*;

    localparam int L = 2;
    localparam int D = 16;
    localparam int C = 16;

    logic          CLK = 1'b0;
    logic          NRST = 1'b0;
    logic          en = 1'b0;
    logic          filter_nodest = 1'b0;
    logic          flush = 1'b0;
    logic [4:0]    level;
    logic          overflow;
    logic [C-1:0]  drop_cnt;

    retire_trace_buf_if #(.LANES(L)) bus ();

    retire_trace_buf #(.LANES(L), .DEPTH(D), .CNT_W(C)) dut (
        .CLK           (CLK),
        .NRST          (NRST),
        .en            (en),
        .filter_nodest (filter_nodest),
        .flush         (flush),
        .bus           (bus),
        .level         (level),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad   = 0;
    int unsigned model_cyc = 0;

    // Reference model state
    trace_rec_t  mq[$];
    logic        m_ovf = 1'b0;
    int unsigned m_drop = 0;

    function automatic logic [166:0] out_fields();
        return {bus.out_pc, bus.out_inst, bus.out_kind, bus.out_rd,
                bus.out_data, bus.out_addr, bus.out_stamp};
    endfunction

    task automatic clear_lanes();
        bus.ret_valid = '0;
        bus.ret_pc    = '0;
        bus.ret_inst  = '0;
        bus.ret_kind  = '0;
        bus.ret_rd    = '0;
        bus.ret_data  = '0;
        bus.ret_addr  = '0;
    endtask

    task automatic set_lane(input int i, input logic [1:0] kind, input logic [31:0] pc,
                            input logic [4:0] rd, input logic [31:0] data,
                            input logic [31:0] addr);
        bus.ret_valid[i] = 1'b1;
        bus.ret_pc[i]    = pc;
        bus.ret_inst[i]  = pc ^ 32'h0000_0013;
        bus.ret_kind[i]  = kind;
        bus.ret_rd[i]    = rd;
        bus.ret_data[i]  = data;
        bus.ret_addr[i]  = addr;
    endtask

    // One clock edge; sampling happens 1 time unit after it.
    task automatic step();
        @(posedge CLK);
        #1;
        model_cyc++;
    endtask

    task automatic do_reset();
        NRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        NRST = 1'b1;
        model_cyc = 0;
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic test_reset();
        en = 1'b1; filter_nodest = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
        clear_lanes();
        NRST = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if ({overflow, drop_cnt} !== 17'd0) begin bad++; $display("FAIL reset_counters got=%0b/%0d want=0/0", overflow, drop_cnt); end
        total++; if (out_fields() !== 167'd0) begin bad++; $display("FAIL reset_fields got=%h want=0", out_fields()); end
        do_reset();
    endtask

    task automatic test_single();
        int unsigned cap;
        clear_lanes();
        set_lane(0, 2'd1, 32'h8000, 5'd5, 32'h1234, 32'h0);
        cap = model_cyc;
        step();
        clear_lanes();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", bus.out_valid); end
        total++; if ({bus.out_pc, bus.out_rd, bus.out_data} !== {32'h8000, 5'd5, 32'h1234}) begin
            bad++; $display("FAIL single_head got pc=%h rd=%0d data=%h want pc=8000 rd=5 data=1234", bus.out_pc, bus.out_rd, bus.out_data); end
        total++; if (bus.out_stamp !== cap) begin bad++; $display("FAIL single_stamp got=%0d want=%0d", bus.out_stamp, cap); end
        total++; if (level !== 5'd1) begin bad++; $display("FAIL single_level got=%0d want=1", level); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        total++; if ({bus.out_valid, level} !== 6'd0) begin bad++; $display("FAIL single_drain got valid=%0b level=%0d want 0/0", bus.out_valid, level); end
    endtask

    task automatic test_back_to_back();
        clear_lanes();
        set_lane(0, 2'd1, 32'h8004, 5'd1, 32'h11, 32'h0);
        set_lane(1, 2'd1, 32'h8008, 5'd2, 32'h22, 32'h0);
        bus.out_ready = 1'b1;
        step();
        clear_lanes();
        total++; if ({bus.out_pc, level} !== {32'h8004, 5'd2}) begin bad++; $display("FAIL b2b_first got pc=%h level=%0d want 8004/2", bus.out_pc, level); end
        step();
        total++; if ({bus.out_pc, level} !== {32'h8008, 5'd1}) begin bad++; $display("FAIL b2b_second got pc=%h level=%0d want 8008/1", bus.out_pc, level); end
        step();
        bus.out_ready = 1'b0;
        total++; if (level !== 5'd0) begin bad++; $display("FAIL b2b_empty got level=%0d want 0", level); end
    endtask

    task automatic test_filter();
        filter_nodest = 1'b1;
        clear_lanes();
        set_lane(0, 2'd0, 32'h9000, 5'd0, 32'h0, 32'h0);
        set_lane(1, 2'd3, 32'h9004, 5'd0, 32'hABCD, 32'hf95c);
        step();
        total++; if (level !== 5'd1) begin bad++; $display("FAIL filter_level got=%0d want=1", level); end
        total++; if ({bus.out_pc, bus.out_kind, bus.out_addr} !== {32'h9004, 2'd3, 32'hf95c}) begin
            bad++; $display("FAIL filter_head got pc=%h kind=%0d addr=%h want 9004/3/f95c", bus.out_pc, bus.out_kind, bus.out_addr); end
        clear_lanes();
        set_lane(0, 2'd2, 32'h9008, 5'd7, 32'h77, 32'h100);
        set_lane(1, 2'd0, 32'h900c, 5'd0, 32'h0, 32'h0);
        step();
        clear_lanes();
        bus.out_ready = 1'b1;
        step();
        total++; if ({bus.out_pc, level} !== {32'h9008, 5'd1}) begin bad++; $display("FAIL filter_order got pc=%h level=%0d want 9008/1", bus.out_pc, level); end
        step();
        bus.out_ready = 1'b0;
        filter_nodest = 1'b0;
    endtask

    task automatic test_overflow();
        clear_lanes();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_lane(0, 2'd1, 32'h1000 + 8 * k, 5'd1, k, 32'h0);
            set_lane(1, 2'd1, 32'h1004 + 8 * k, 5'd2, k, 32'h0);
            step();
        end
        total++; if ({level, overflow} !== {5'd16, 1'b0}) begin bad++; $display("FAIL ovf_fill got level=%0d ovf=%0b want 16/0", level, overflow); end
        step();
        total++; if ({level, overflow, drop_cnt} !== {5'd16, 1'b1, 16'd2}) begin
            bad++; $display("FAIL ovf_drop got level=%0d ovf=%0b drop=%0d want 16/1/2", level, overflow, drop_cnt); end
        total++; if (bus.out_pc !== 32'h1000) begin bad++; $display("FAIL ovf_head got=%h want=1000", bus.out_pc); end
        clear_lanes();
        set_lane(0, 2'd1, 32'h2000, 5'd3, 32'h0, 32'h0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        clear_lanes();
        total++; if ({level, drop_cnt, bus.out_pc} !== {5'd15, 16'd3, 32'h1004}) begin
            bad++; $display("FAIL ovf_nocredit got level=%0d drop=%0d pc=%h want 15/3/1004", level, drop_cnt, bus.out_pc); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        set_lane(0, 2'd1, 32'h3000, 5'd1, 32'h0, 32'h0);
        set_lane(1, 2'd1, 32'h3004, 5'd1, 32'h0, 32'h0);
        step();
        flush = 1'b0;
        total++; if ({level, bus.out_valid, drop_cnt} !== {5'd0, 1'b0, 16'd3}) begin
            bad++; $display("FAIL flush_full got level=%0d valid=%0b drop=%0d want 0/0/3", level, bus.out_valid, drop_cnt); end
        step();
        step();
        clear_lanes();
        set_lane(0, 2'd1, 32'h3010, 5'd1, 32'h0, 32'h0);
        step();
        total++; if ({level, bus.out_pc} !== {5'd5, 32'h3000}) begin bad++; $display("FAIL flush_refill got level=%0d pc=%h want 5/3000", level, bus.out_pc); end
        flush = 1'b1;
        bus.out_ready = 1'b1;
        set_lane(1, 2'd1, 32'h3014, 5'd1, 32'h0, 32'h0);
        step();
        flush = 1'b0;
        bus.out_ready = 1'b0;
        clear_lanes();
        total++; if ({level, bus.out_valid, drop_cnt, overflow} !== {5'd0, 1'b0, 16'd3, 1'b1}) begin
            bad++; $display("FAIL flush_five got level=%0d valid=%0b drop=%0d ovf=%0b want 0/0/3/1", level, bus.out_valid, drop_cnt, overflow); end
    endtask

    task automatic test_reset_mid();
        set_lane(0, 2'd1, 32'h4000, 5'd1, 32'h0, 32'h0);
        set_lane(1, 2'd1, 32'h4004, 5'd1, 32'h0, 32'h0);
        step();
        clear_lanes();
        bus.out_ready = 1'b1;
        step();
        #2;
        NRST = 1'b0;
        #1;
        total++; if ({bus.out_valid, level, overflow, drop_cnt} !== 23'd0) begin
            bad++; $display("FAIL rstmid_state got valid=%0b level=%0d ovf=%0b drop=%0d want all 0", bus.out_valid, level, overflow, drop_cnt); end
        total++; if (out_fields() !== 167'd0) begin bad++; $display("FAIL rstmid_fields got=%h want=0", out_fields()); end
        bus.out_ready = 1'b0;
        do_reset();
    endtask

    // Reference model: applies one cycle of the current inputs to the queue.
    task automatic model_cycle();
        trace_rec_t grp[$];
        trace_rec_t r;
        logic       do_pop;
        if (flush) begin
            mq.delete();
            return;
        end
        for (int i = 0; i < L; i++) begin
            if (en && bus.ret_valid[i] && !(filter_nodest && bus.ret_kind[i] == 2'd0)) begin
                r.pc    = bus.ret_pc[i];
                r.inst  = bus.ret_inst[i];
                r.kind  = trace_kind_e'(bus.ret_kind[i]);
                r.rd    = bus.ret_rd[i];
                r.data  = bus.ret_data[i];
                r.addr  = bus.ret_addr[i];
                r.stamp = model_cyc;
                grp.push_back(r);
            end
        end
        do_pop = (mq.size() > 0) && bus.out_ready;
        if (grp.size() > D - mq.size()) begin
            m_ovf  = 1'b1;
            m_drop = (m_drop + grp.size() > 65535) ? 65535 : m_drop + grp.size();
            grp.delete();
        end
        if (do_pop) void'(mq.pop_front());
        foreach (grp[k]) mq.push_back(grp[k]);
    endtask

    task automatic test_random();
        logic [166:0] exp_head;
        clear_lanes();
        for (int c = 0; c < 600; c++) begin
            en            = ($urandom_range(0, 9) != 0);
            filter_nodest = $urandom_range(0, 1);
            flush         = ($urandom_range(0, 39) == 0);
            bus.out_ready = (c < 300) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            for (int i = 0; i < L; i++) begin
                bus.ret_valid[i] = ($urandom_range(0, 9) < 7);
                bus.ret_pc[i]    = $urandom;
                bus.ret_inst[i]  = $urandom;
                bus.ret_kind[i]  = 2'($urandom_range(0, 3));
                bus.ret_rd[i]    = 5'($urandom_range(0, 31));
                bus.ret_data[i]  = $urandom;
                bus.ret_addr[i]  = $urandom;
            end
            model_cycle();
            step();
            exp_head = (mq.size() > 0) ? mq[0] : '0;
            total++; if (bus.out_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", c, bus.out_valid, mq.size() > 0); end
            total++; if (level !== 5'(mq.size())) begin bad++; $display("FAIL rnd_level cyc=%0d got=%0d want=%0d", c, level, mq.size()); end
            total++; if ({overflow, drop_cnt} !== {m_ovf, 16'(m_drop)}) begin
                bad++; $display("FAIL rnd_counters cyc=%0d got=%0b/%0d want=%0b/%0d", c, overflow, drop_cnt, m_ovf, m_drop); end
            total++; if (out_fields() !== exp_head) begin bad++; $display("FAIL rnd_head cyc=%0d got=%h want=%h", c, out_fields(), exp_head); end
        end
        flush = 1'b0;
        en    = 1'b1;
        clear_lanes();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_filter();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
